// File: rtl/axi4_wr_slave_mem_if.sv
// axi4_wr_slave_mem_if: AXI4 write-channel bundle (AW, W, B) between a master and the memory slave
interface axi4_wr_slave_mem_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  modport master (
    output awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport slave (
    input  awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi4_wr_slave_mem.sv
// axi4_wr_slave_mem: single-outstanding AXI4 write slave into a byte-strobed word memory with backdoor read
module axi4_wr_slave_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  axi4_wr_slave_mem_if.slave s,
  input  logic [IW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       burst_cnt
);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  // one spare index bit so an INCR burst running off the top is seen as out of range, not wrapped
  localparam int XW = ADDR_W - 1;
  state_t            state_q, state_d;
  logic [XW-1:0]     idx_q, idx_d;
  logic [7:0]        len_q, len_d, beat_q, beat_d;
  logic              fixed_q, fixed_d, err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              aw_hs, w_hs, b_hs, in_range, last_beat, we;
  logic              unused_addr;
  assign aw_hs       = s.awvalid & s.awready;
  assign w_hs        = s.wvalid & s.wready;
  assign b_hs        = s.bvalid & s.bready;
  assign in_range    = idx_q < XW'(DEPTH);
  assign last_beat   = beat_q == len_q;
  assign we          = w_hs & in_range;
  assign rd_data     = rd_data_q;
  assign burst_cnt   = cnt_q;
  assign unused_addr = ^s.awaddr[1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      fixed_q <= fixed_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we && s.wstrb[b]) mem[idx_q[IW-1:0]][8*b +: 8] <= s.wdata[8*b +: 8];
    rd_data_q <= mem[rd_addr];
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    beat_d  = beat_q;
    fixed_d = fixed_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (aw_hs) begin
        state_d = DATA;
        idx_d   = XW'(s.awaddr[ADDR_W-1:2]);
        len_d   = s.awlen;
        beat_d  = '0;
        fixed_d = s.awburst == 2'b00;
        err_d   = s.awburst[1];
      end
      DATA: if (w_hs) begin
        beat_d  = beat_q + 8'd1;
        idx_d   = fixed_q ? idx_q : idx_q + XW'(1);
        err_d   = err_q | ~in_range | (s.wlast != last_beat);
        state_d = last_beat ? RESP : DATA;
      end
      RESP: if (b_hs) begin
        state_d = IDLE;
        cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    s.awready = ~reset & (state_q == IDLE);
    s.wready  = ~reset & (state_q == DATA);
    s.bvalid  = ~reset & (state_q == RESP);
    s.bresp   = (~reset & (state_q == RESP) & err_q) ? 2'b10 : 2'b00;
  end
endmodule

// File: doc/axi4_wr_slave_mem.md
AXI4_WR_SLAVE_MEM -- requirements
Module: axi4_wr_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI4 address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width, fixed 32 (4 byte lanes).
REQ-003 SHALL have parameter DEPTH, default 256: memory depth in 32-bit words, power of two.
REQ-004 SHALL have port clk  in  1: single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have ports awaddr in ADDR_W, awlen in 8, awburst in 2, awvalid in 1, awready out 1: AXI4 write address channel.
REQ-007 SHALL have ports wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1: AXI4 write data channel.
REQ-008 SHALL have ports bresp out 2, bvalid out 1, bready in 1: AXI4 write response channel.
REQ-009 SHALL have ports rd_addr in log2(DEPTH), rd_data out 32: backdoor word read port for consumers/bench.
REQ-010 SHALL have port burst_cnt out 16: count of completed write bursts (B handshakes).

Function
REQ-011 SHALL implement FSM states IDLE, DATA, RESP; awready=1 only in IDLE, wready=1 only in DATA, bvalid=1 only in RESP.
REQ-012 IDLE: on awvalid&&awready SHALL latch word index awaddr[ADDR_W-1:2], awlen, awburst; clear beat counter and error flag; go to DATA next cycle.
REQ-013 Burst type: FIXED (00) SHALL hold index every beat; INCR (01) SHALL add 1 per beat; WRAP (10) or reserved (11) SHALL set error flag and behave as INCR.
REQ-014 DATA: each wvalid&&wready beat SHALL write bytes of wdata whose wstrb bit is 1 into mem[index]; strobed-off bytes unchanged.
REQ-015 A beat whose index >= DEPTH (including INCR running past DEPTH-1) SHALL not write memory and SHALL set error flag; no modulo wrap.
REQ-016 wlast SHALL be checked per beat: wlast=1 with beat count < awlen, or wlast=0 on beat count == awlen, SHALL set error flag.
REQ-017 Burst length SHALL be awlen+1 beats taken from AW only; on beat count == awlen SHALL go to RESP next cycle regardless of wlast.
REQ-018 RESP: bresp SHALL be 2'b10 (SLVERR) if error flag set else 2'b00 (OKAY); bvalid and bresp SHALL stay stable until bready.
REQ-019 On bvalid&&bready SHALL return to IDLE next cycle, increment burst_cnt (wraps 16'hFFFF->0); awready high in that next cycle.
REQ-020 Throughput: single-beat burst SHALL take AW cycle + 1 W cycle + >=1 B cycle; no AW acceptance while DATA or RESP (one outstanding burst).
REQ-021 wvalid in IDLE or RESP SHALL be ignored (wready=0); awvalid in DATA/RESP SHALL be stalled (awready=0).
REQ-022 rd_data SHALL equal mem[rd_addr] registered with 1-cycle latency; same-cycle write/read of one word SHALL return old data.
REQ-023 Address bits awaddr[1:0] SHALL be ignored (word-aligned); awsize implied 3'b010.

Reset
REQ-024 With reset high at a clk edge: state=IDLE, awready=0 during reset cycle then 1, wready=0, bvalid=0, bresp=2'b00, burst_cnt=0, error flag=0.
REQ-025 Reset mid-burst (DATA or RESP) SHALL abort burst without B response; words already written SHALL remain; memory contents never cleared by reset.
REQ-026 rd_data value after reset SHALL be don't-care until first read cycle completes.

Verification
REQ-027 INCR awaddr=0x10, awlen=3, wdata 0xA5A5_0000..0003, wstrb=F, wlast on beat 3 -> mem[4..7] hold data, bresp=00, burst_cnt=1.
REQ-028 Single beat awaddr=0x0 wdata=0x1122_3344 wstrb=4'b0101 over mem[0]=0 -> mem[0]=0x0022_0044, bresp=00.
REQ-029 INCR awaddr=(DEPTH-2)*4, awlen=3 -> mem[DEPTH-2..DEPTH-1] written, beats 2-3 dropped, mem[0..1] untouched, bresp=10.
REQ-030 awlen=2 with wlast on beat 1 -> 3 beats still accepted, bresp=10; bready held low 5 cycles -> bvalid/bresp stable, awready=0 throughout.
REQ-031 FIXED awaddr=0x20, awlen=1, data 0x1 then 0x2 -> mem[8]=0x2, bresp=00; WRAP burst -> bresp=10.
REQ-032 reset asserted after beat 1 of 4-beat burst -> bvalid never asserted, awready=1 after reset, beats 0-1 retained, next burst completes with bresp=00, burst_cnt=1.
